// File: rtl/fwd_layer_engine.sv
// Forward-pass engine for one fully connected layer: one signed MAC per cycle, then shift/activate/saturate per neuron.
// Optional build macro FWD_LAYER_RELU_EN adds ReLU ahead of saturation; undefined keeps signed outputs.
module fwd_layer_engine #(
    parameter int N_IN  = 4,
    parameter int N_OUT = 4,
    parameter int DW    = 8,
    parameter int SHIFT = 2,
    parameter int ACC_W = 2*DW + $clog2(N_IN) + 1
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              en_i,
    input  logic                              pass_i,
    input  logic                              w_we_i,
    input  logic [$clog2(N_OUT*(N_IN+1))-1:0] w_addr_i,
    input  logic [DW-1:0]                     w_data_i,
    input  logic                              x_we_i,
    input  logic [$clog2(N_IN)-1:0]           x_addr_i,
    input  logic [DW-1:0]                     x_data_i,
    input  logic [$clog2(N_OUT)-1:0]          y_addr_i,
    output logic [DW-1:0]                     y_data_o,
    output logic                              busy_o,
    output logic                              end_o
);

    localparam int W_DEPTH = N_OUT*(N_IN+1);
    localparam int WAW     = $clog2(W_DEPTH);
    localparam int XAW     = $clog2(N_IN);
    localparam int OW      = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MAC  = 3'd1;
    localparam logic [2:0] S_ACT  = 3'd2;
    localparam logic [2:0] S_DONE = 3'd3;
    localparam logic [2:0] S_WAIT = 3'd4;

    localparam logic [OW-1:0]  O_LAST = OW'(N_OUT-1);
    localparam logic [XAW-1:0] I_LAST = XAW'(N_IN-1);

    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((2**(DW-1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

    logic [2:0]               state_q, state_d;
    logic [OW-1:0]            o_q, o_d;
    logic [XAW-1:0]           i_q, i_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [DW-1:0]     y_q [N_OUT];
    logic signed [DW-1:0]     y_d [N_OUT];
    logic signed [DW-1:0]     w_mem_q [W_DEPTH];
    logic signed [DW-1:0]     w_mem_d [W_DEPTH];
    logic signed [DW-1:0]     x_mem_q [N_IN];
    logic signed [DW-1:0]     x_mem_d [N_IN];

    logic [OW-1:0]            o_nxt;
    logic [WAW-1:0]           bias_idx;
    logic [WAW-1:0]           w_idx;
    logic signed [ACC_W-1:0]  bias_acc;
    logic signed [2*DW-1:0]   prod;
    logic signed [ACC_W-1:0]  prod_ext;

    function automatic logic signed [DW-1:0] act_sat(input logic signed [ACC_W-1:0] t);
        logic signed [ACC_W-1:0] v;
        v = t;
`ifdef FWD_LAYER_RELU_EN
        if (v[ACC_W-1]) v = '0;
`endif
        if (v > SAT_HI)      act_sat = SAT_HI[DW-1:0];
        else if (v < SAT_LO) act_sat = SAT_LO[DW-1:0];
        else                 act_sat = v[DW-1:0];
    endfunction

    assign busy_o   = (state_q == S_MAC) || (state_q == S_ACT) || (state_q == S_DONE);
    assign end_o    = (state_q == S_DONE);
    assign y_data_o = y_q[y_addr_i];

    // Host-side buffer writes are locked out while a pass is running.
    always_comb begin
        w_mem_d = w_mem_q;
        x_mem_d = x_mem_q;
        if (!busy_o) begin
            if (w_we_i && ({1'b0, w_addr_i} < (WAW+1)'(W_DEPTH))) w_mem_d[w_addr_i] = $signed(w_data_i);
            if (x_we_i) x_mem_d[x_addr_i] = $signed(x_data_i);
        end
    end

    // Operand fetch: the bias index points at the neuron about to be started.
    always_comb begin
        o_nxt    = ((state_q == S_ACT) && (o_q != O_LAST)) ? o_q + OW'(1) : '0;
        bias_idx = WAW'(N_OUT*N_IN) + WAW'(o_nxt);
        bias_acc = ACC_W'(w_mem_q[bias_idx]) <<< SHIFT;
        w_idx    = WAW'(o_q) * WAW'(N_IN) + WAW'(i_q);
        prod     = (2*DW)'(w_mem_q[w_idx]) * (2*DW)'(x_mem_q[i_q]);
        prod_ext = ACC_W'(prod);
    end

    always_comb begin
        state_d = state_q;
        o_d     = o_q;
        i_d     = i_q;
        acc_d   = acc_q;
        y_d     = y_q;
        if (en_i) begin
            case (state_q)
                S_IDLE: begin
                    if (pass_i) begin
                        acc_d   = bias_acc;
                        o_d     = '0;
                        i_d     = '0;
                        state_d = S_MAC;
                    end
                end
                S_MAC: begin
                    acc_d = acc_q + prod_ext;
                    if (i_q == I_LAST) state_d = S_ACT;
                    else               i_d = i_q + XAW'(1);
                end
                S_ACT: begin
                    y_d[o_q] = act_sat(acc_q >>> SHIFT);
                    if (o_q == O_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        o_d     = o_q + OW'(1);
                        i_d     = '0;
                        acc_d   = bias_acc;
                        state_d = S_MAC;
                    end
                end
                S_DONE: state_d = S_WAIT;
                // Hold here until the sequencer drops its level, so a held pass_i cannot re-trigger.
                S_WAIT: if (!pass_i) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            o_q     <= '0;
            i_q     <= '0;
            acc_q   <= '0;
            for (int k = 0; k < N_OUT; k++) y_q[k] <= '0;
        end else begin
            state_q <= state_d;
            o_q     <= o_d;
            i_q     <= i_d;
            acc_q   <= acc_d;
            y_q     <= y_d;
        end
    end

    always_ff @(posedge clk_i) begin
        w_mem_q <= w_mem_d;
        x_mem_q <= x_mem_d;
    end

endmodule

// File: tb/tb_fwd_layer_engine.sv
// Directed bench for fwd_layer_engine: table of full-layer vectors plus hand sequences for hold, stall, lockout and reset.
module tb_fwd_layer_engine;

`ifdef FWD_LAYER_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic       clk_i = 1'b0;
    logic       rst_i, en_i, pass_i;
    logic       w_we_i, x_we_i;
    logic [4:0] w_addr_i;
    logic [7:0] w_data_i;
    logic [1:0] x_addr_i;
    logic [7:0] x_data_i;
    logic [1:0] y_addr_i;
    logic [7:0] y_data_o;
    logic       busy_o, end_o;

    int nvec = 0;
    int nerr = 0;

    always #5 clk_i = ~clk_i;

    fwd_layer_engine dut (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .pass_i(pass_i),
        .w_we_i(w_we_i), .w_addr_i(w_addr_i), .w_data_i(w_data_i),
        .x_we_i(x_we_i), .x_addr_i(x_addr_i), .x_data_i(x_data_i),
        .y_addr_i(y_addr_i), .y_data_o(y_data_o),
        .busy_o(busy_o), .end_o(end_o)
    );

    typedef struct {
        logic [3:0][7:0]      x;
        logic [3:0][3:0][7:0] w;
        logic [3:0][7:0]      b;
        logic [3:0][7:0]      y;
    } vec_t;

    vec_t tv [3];

    function automatic logic [3:0][7:0] q4(input int a, input int b, input int c, input int d);
        logic [3:0][7:0] r;
        r[0] = a[7:0];
        r[1] = b[7:0];
        r[2] = c[7:0];
        r[3] = d[7:0];
        return r;
    endfunction

    function automatic int exp_y(input logic [7:0] raw);
        int r;
        r = int'($signed(raw));
        if (RELU && r < 0) r = 0;
        return r;
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] expv);
        nvec++;
        if (act !== expv) begin
            nerr++;
            $display("FAIL %s: got %0d, want %0d", nm, act, expv);
        end
    endtask

    task automatic write_w(input int a, input logic [7:0] d);
        w_we_i   = 1'b1;
        w_addr_i = a[4:0];
        w_data_i = d;
        step();
        w_we_i   = 1'b0;
    endtask

    task automatic write_x(input int a, input logic [7:0] d);
        x_we_i   = 1'b1;
        x_addr_i = a[1:0];
        x_data_i = d;
        step();
        x_we_i   = 1'b0;
    endtask

    task automatic load_vec(input int v);
        for (int o = 0; o < 4; o++) begin
            for (int i = 0; i < 4; i++) write_w(o*4 + i, tv[v].w[o][i]);
            write_w(16 + o, tv[v].b[o]);
        end
        for (int i = 0; i < 4; i++) write_x(i, tv[v].x[i]);
    endtask

    task automatic check_y(input int v, input string tag);
        for (int o = 0; o < 4; o++) begin
            y_addr_i = o[1:0];
            #1;
            chk($sformatf("%s_y%0d", tag, o), $signed(y_data_o), exp_y(tv[v].y[o]));
        end
    endtask

    task automatic check_y_zero(input string tag);
        for (int o = 0; o < 4; o++) begin
            y_addr_i = o[1:0];
            #1;
            chk($sformatf("%s_y%0d", tag, o), $signed(y_data_o), 0);
        end
    endtask

    // k counts edges from the one that samples pass_i=1 (edge 0); lat is the edge after which end_o is seen.
    task automatic run_pass(input int stall_at, input int stall_len, input int wr_at,
                            input bit hold, output int lat);
        int  k;
        bit  found;
        k      = -1;
        found  = 1'b0;
        pass_i = 1'b1;
        en_i   = 1'b1;
        while (!found && k < 100) begin
            step();
            k++;
            en_i = !(k >= stall_at && k < stall_at + stall_len);
            if (k == wr_at) begin
                w_we_i   = 1'b1;
                w_addr_i = 5'd15;
                w_data_i = 8'd50;
            end else begin
                w_we_i = 1'b0;
            end
            if (k == 1) chk("busy_edge1", busy_o, 1);
            if (end_o) found = 1'b1;
        end
        en_i   = 1'b1;
        w_we_i = 1'b0;
        lat    = found ? k : -1;
        if (found) chk("busy_in_done", busy_o, 1);
        step();
        chk("end_single_pulse", end_o, 0);
        chk("busy_after_done", busy_o, 0);
        if (!hold) begin
            pass_i = 1'b0;
            step();
            step();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1);
    end

    initial begin
        int lat;
        bit seen;

        rst_i = 1'b1; en_i = 1'b1; pass_i = 1'b0;
        w_we_i = 1'b0; w_addr_i = '0; w_data_i = '0;
        x_we_i = 1'b0; x_addr_i = '0; x_data_i = '0;
        y_addr_i = '0;

        // x, rows w[0..3], biases, raw expected y (before optional ReLU)
        tv[0].x = q4(1, 2, 3, 4);
        tv[0].w[0] = q4(1, 1, 1, 1);     tv[0].w[1] = q4(0, 0, 0, 0);
        tv[0].w[2] = q4(-1, -1, -1, -1); tv[0].w[3] = q4(0, 0, 0, 0);
        tv[0].b = q4(0, 0, 0, 5);
        tv[0].y = q4(2, 0, -3, 5);

        tv[1].x = q4(127, 127, 127, 127);
        tv[1].w[0] = q4(0, 0, 0, 0);         tv[1].w[1] = q4(127, 127, 127, 127);
        tv[1].w[2] = q4(-128, -128, -128, -128); tv[1].w[3] = q4(1, -1, 2, -2);
        tv[1].b = q4(0, 0, -128, 3);
        tv[1].y = q4(0, 127, -128, 3);

        tv[2].x = q4(-5, 7, 0, 100);
        tv[2].w[0] = q4(2, 3, 4, 1);         tv[2].w[1] = q4(-1, -1, -1, -1);
        tv[2].w[2] = q4(127, 127, 127, 127); tv[2].w[3] = q4(0, 0, 0, 1);
        tv[2].b = q4(-1, 10, 127, -128);
        tv[2].y = q4(26, -16, 127, -103);

        step();
        step();
        chk("rst_busy", busy_o, 0);
        chk("rst_end", end_o, 0);
        rst_i = 1'b0;
        check_y_zero("rst");

        for (int v = 0; v < 3; v++) begin
            load_vec(v);
            run_pass(-100, 0, -1, 1'b0, lat);
            chk($sformatf("latency_v%0d", v), lat, 20);
            check_y(v, $sformatf("v%0d", v));
        end

        // Held pass level: no re-run until pass_i drops and rises again.
        load_vec(0);
        run_pass(-100, 0, -1, 1'b1, lat);
        chk("latency_held", lat, 20);
        seen = 1'b0;
        repeat (12) begin
            step();
            if (end_o) seen = 1'b1;
        end
        chk("held_no_rerun", seen, 0);
        chk("held_busy", busy_o, 0);
        pass_i = 1'b0;
        step();
        step();
        run_pass(-100, 0, -1, 1'b0, lat);
        chk("latency_rerun", lat, 20);
        check_y(0, "rerun");

        // Three-cycle stall mid-MAC with a weight write attempted while busy.
        run_pass(6, 3, 2, 1'b0, lat);
        chk("latency_stall", lat, 23);
        check_y(0, "stall");
        run_pass(-100, 0, -1, 1'b0, lat);
        chk("latency_after_lock", lat, 20);
        check_y(0, "after_lock");

        // Reset landing on edge 7 of a pass.
        pass_i = 1'b1;
        en_i   = 1'b1;
        repeat (7) step();
        rst_i  = 1'b1;
        pass_i = 1'b0;
        step();
        chk("midrst_busy", busy_o, 0);
        chk("midrst_end", end_o, 0);
        rst_i = 1'b0;
        check_y_zero("midrst");
        seen = 1'b0;
        repeat (30) begin
            step();
            if (end_o) seen = 1'b1;
        end
        chk("midrst_no_end", seen, 0);
        run_pass(-100, 0, -1, 1'b0, lat);
        chk("latency_post_rst", lat, 20);
        check_y(0, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/fwd_layer_engine.md
Name: fwd_layer_engine

Overview:
- Compute engine for the forward pass of one fully connected layer.
- Sits directly upstream of the training-pass sequencer: it is started by the sequencer's forward-pass level and returns the end pulse that advances the sequencer (f0_end).
- Holds local weight, bias, input and output buffers. Runs a single signed MAC per cycle, then activation and saturation per neuron.

Parameters:
- N_IN, 4, inputs per neuron (>=2)
- N_OUT, 4, neurons in layer (>=1)
- DW, 8, signed data/weight width
- SHIFT, 2, arithmetic right shift applied to accumulator before saturation
- ACC_W, 2*DW+$clog2(N_IN)+1, signed accumulator width (derived, do not override)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- en_i  in  1  global enable; low freezes FSM, counters, accumulator
- pass_i  in  1  start level from sequencer; held high until end_o seen
- w_we_i  in  1  weight/bias write strobe
- w_addr_i  in  $clog2(N_OUT*(N_IN+1))  row o, input i at o*N_IN+i; bias o at N_OUT*N_IN+o
- w_data_i  in  DW  signed weight/bias
- x_we_i  in  1  input vector write strobe
- x_addr_i  in  $clog2(N_IN)  input index
- x_data_i  in  DW  signed input
- y_addr_i  in  $clog2(N_OUT)  output read index
- y_data_o  out  DW  output buffer read data (combinational read)
- busy_o  out  1  high in MAC/ACT/DONE
- end_o  out  1  one-cycle completion pulse (to sequencer f0_end)

Behaviour:
- Clock and reset: one clock clk_i; synchronous active-high reset rst_i.
- Reset values: state IDLE, end_o=0, busy_o=0, counters=0, accumulator=0, output buffer all 0. Weight, bias and input buffers are not reset.
- Host writes: w_we_i / x_we_i take effect at the clock edge when busy_o=0, independent of en_i. Writes while busy_o=1 are ignored. Out-of-range w_addr_i is ignored.

FSM (advances only when en_i=1):
- IDLE: when pass_i=1, load acc = sext(bias[0])<<SHIFT, set o=0, i=0, go to MAC.
- MAC: acc += sext(w[o][i]) * sext(x[i]) (full-precision signed product). If i==N_IN-1, go to ACT; else i++.
- ACT: t = acc >>> SHIFT (arithmetic); y[o] = sat(t). If o==N_OUT-1, go to DONE; else o++, i=0, acc = sext(bias[o+1])<<SHIFT, back to MAC.
- DONE: end_o=1 for this single cycle; go to WAIT.
- WAIT: busy_o=0; stay until pass_i=0, then go to IDLE. This prevents a re-run on a held level.

Timing:
- Latency: the edge sampling pass_i=1 in IDLE is edge 0. end_o is high in the cycle after edge N_OUT*(N_IN+1) (edge 20 at defaults), assuming en_i stays high.
- en_i low mid-pass stretches latency by the number of low cycles; no state, counter or accumulator change while en_i is low.

Saturation:
- sat() clamps to [-2^(DW-1), 2^(DW-1)-1].
- The accumulator cannot overflow by construction of ACC_W.

Boundary conditions:
- pass_i dropping mid-pass does not abort; the pass completes, end_o pulses, then WAIT exits immediately.
- Reset mid-pass returns to IDLE and clears the output buffer; end_o is not pulsed.
- y_data_o reads during a pass return the old value for neurons not yet written.

Optional Feature:
- Macro: FWD_LAYER_RELU_EN.
- Defined: ACT applies ReLU before saturation, so negative t yields 0 and the output range is [0, 2^(DW-1)-1].
- Undefined: plain signed saturation only; negative outputs are kept.

Test Plan:
- Basic MAC and end timing: reset; x={1,2,3,4}; row0 w={1,1,1,1}, bias0=0; pulse pass_i high -> y[0]=2 (10>>>2). end_o is a single pulse after edge 20, and busy_o is high from edge 1 through DONE.
- Positive saturation: x all 127, row1 w all 127, bias1=0 -> acc 64516, >>>2 = 16129 -> y[1]=127.
- Negative result: x={1,2,3,4}, row2 w all -1, bias2=0 -> y[2]=0 with FWD_LAYER_RELU_EN, y[2]=-3 (0xFD) without. Also bias2=-128, w all -128, x all 127 -> y[2]=-128 without the macro.
- Bias path: row3 w all 0, bias3=5 -> y[3]=5. Second pass with pass_i held high across WAIT -> no second end_o until pass_i goes low and then high again.
- Stall and write lockout: drop en_i for 3 cycles mid-MAC -> end_o arrives 3 cycles later with the same results. A w_we_i write during busy leaves the next pass's results unchanged.
- Reset mid-pass: assert rst_i at edge 7 -> busy_o=0, all y=0, no end_o. A new pass afterwards completes normally.
